// File: rtl/fb_writer_pkg.sv
// fb_writer_pkg: raster-side shared definitions used by the framebuffer writer.
// Holds the color width, fixed-point fraction width, the 2-D coordinate type
// emitted by the raster pipeline, and the writer FSM state encoding.
package fb_writer_pkg;

  localparam int COLOR_BITS   = 16;
  localparam int FX_FRAC_BITS = 4;
  localparam int COORD_BITS   = 16;

  // Signed fixed-point position, FX_FRAC_BITS fractional bits per axis.
  typedef struct packed {
    logic signed [COORD_BITS-1:0] x;
    logic signed [COORD_BITS-1:0] y;
  } coord_2d_t;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_CLEAR = 1'b1
  } fb_state_t;

endpackage

// File: rtl/fb_writer_addr_gen.sv
// fb_addr_gen: combinational coordinate-to-address mapper.
// Floors the fixed-point position to integer pixel coordinates, checks them
// against the framebuffer bounds and linearizes to a row-major address.
// Ports:
//   pixel     in   fixed-point pixel position
//   in_bounds out  1 when 0 <= xi < FB_WIDTH and 0 <= yi < FB_HEIGHT
//   addr      out  yi*FB_WIDTH + xi truncated to ADDR_W (valid when in_bounds)
module fb_addr_gen
  import fb_writer_pkg::*;
#(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 240,
  parameter int ADDR_W    = 17
) (
  input  coord_2d_t         pixel,
  output logic              in_bounds,
  output logic [ADDR_W-1:0] addr
);

  logic signed [31:0] x_ext;
  logic signed [31:0] y_ext;
  logic signed [31:0] xi;
  logic signed [31:0] yi;

  always_comb begin
    x_ext = 32'(pixel.x);
    y_ext = 32'(pixel.y);
    // arithmetic shift of a signed value floors toward minus infinity
    xi = x_ext >>> FX_FRAC_BITS;
    yi = y_ext >>> FX_FRAC_BITS;
    in_bounds = (xi >= 0) && (xi < FB_WIDTH) && (yi >= 0) && (yi < FB_HEIGHT);
    addr = ADDR_W'(yi * FB_WIDTH + xi);
  end

endmodule

// File: rtl/fb_writer.sv
// fb_writer: pixel sink that turns the rasterizer vld/rdy fragment stream into
// single-port framebuffer writes, drops off-screen fragments, backpressures
// while memory stalls, and runs a full-frame clear sweep on request.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   vld_in/rdy_in         pixel stream handshake
//   color_in, pixel_in    fragment color and fixed-point position
//   clear_req/clear_busy  clear sweep start pulse / pending-or-running flag
//   mem_req/mem_gnt       write request and grant
//   mem_addr/mem_wdata    write address and data (stable while stalled)
//   wr_count/drop_count   pixel writes / dropped fragments
// Build option: define FB_STATS_EN to include the two statistics counters;
// without it both counter outputs are tied to zero.
//
// state   | meaning
// S_RUN   | pixel writes from the hold register; clear may be pending
// S_CLEAR | sweeping CLEAR_COLOR over every framebuffer address
module fb_writer
  import fb_writer_pkg::*;
#(
  parameter int                    FB_WIDTH    = 320,
  parameter int                    FB_HEIGHT   = 240,
  parameter int                    ADDR_W      = 17,
  parameter logic [COLOR_BITS-1:0] CLEAR_COLOR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vld_in,
  output logic                  rdy_in,
  input  logic [COLOR_BITS-1:0] color_in,
  input  coord_2d_t             pixel_in,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [COLOR_BITS-1:0] mem_wdata,
  output logic [31:0]           wr_count,
  output logic [31:0]           drop_count
);

  localparam int                FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

  fb_state_t             state_q, state_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [ADDR_W-1:0]     hold_addr_q, hold_addr_d;
  logic [COLOR_BITS-1:0] hold_color_q, hold_color_d;
  logic                  clear_pend_q, clear_pend_d;
  logic [ADDR_W-1:0]     clr_addr_q, clr_addr_d;

  logic                  px_in_bounds;
  logic [ADDR_W-1:0]     px_addr;
  logic                  px_accept;
  logic                  wr_done;
  logic                  clr_last;

  fb_addr_gen #(
    .FB_WIDTH (FB_WIDTH),
    .FB_HEIGHT(FB_HEIGHT),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .pixel    (pixel_in),
    .in_bounds(px_in_bounds),
    .addr     (px_addr)
  );

  assign px_accept = vld_in && rdy_in;
  assign wr_done   = mem_req && mem_gnt;
  assign clr_last  = (state_q == S_CLEAR) && mem_gnt && (clr_addr_q == LAST_ADDR);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // next state: the held pixel always drains before the sweep starts
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (clear_pend_q && !hold_vld_q) state_d = S_CLEAR;
      S_CLEAR: if (clr_last) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // outputs
  always_comb begin
    rdy_in     = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = hold_addr_q;
    mem_wdata  = hold_color_q;
    clear_busy = clear_pend_q || (state_q == S_CLEAR);
    case (state_q)
      S_RUN: begin
        mem_req = hold_vld_q;
        // a grant frees the hold register in time for a same-cycle refill
        rdy_in  = !clear_pend_q && (!hold_vld_q || mem_gnt);
      end
      S_CLEAR: begin
        mem_req   = 1'b1;
        mem_addr  = clr_addr_q;
        mem_wdata = CLEAR_COLOR;
      end
      default: ;
    endcase
  end

  // datapath next values
  always_comb begin
    hold_vld_d   = hold_vld_q;
    hold_addr_d  = hold_addr_q;
    hold_color_d = hold_color_q;
    clear_pend_d = clear_pend_q;
    clr_addr_d   = clr_addr_q;

    if ((state_q == S_RUN) && wr_done) hold_vld_d = 1'b0;
    if (px_accept && px_in_bounds) begin
      hold_vld_d   = 1'b1;
      hold_addr_d  = px_addr;
      hold_color_d = color_in;
    end

    // requests arriving while a clear is pending or running are dropped
    if (clear_req && (state_q == S_RUN) && !clear_pend_q) clear_pend_d = 1'b1;

    if ((state_q == S_CLEAR) && mem_gnt) begin
      clr_addr_d = clr_last ? '0 : clr_addr_q + ADDR_W'(1);
    end
    if (clr_last) clear_pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_vld_q   <= 1'b0;
      hold_addr_q  <= '0;
      hold_color_q <= '0;
      clear_pend_q <= 1'b0;
      clr_addr_q   <= '0;
    end else begin
      hold_vld_q   <= hold_vld_d;
      hold_addr_q  <= hold_addr_d;
      hold_color_q <= hold_color_d;
      clear_pend_q <= clear_pend_d;
      clr_addr_q   <= clr_addr_d;
    end
  end

`ifdef FB_STATS_EN
  logic [31:0] wr_count_q, wr_count_d;
  logic [31:0] drop_count_q, drop_count_d;

  // clear writes are excluded from wr_count
  always_comb begin
    wr_count_d   = wr_count_q + 32'((state_q == S_RUN) && wr_done);
    drop_count_d = drop_count_q + 32'(px_accept && !px_in_bounds);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      wr_count_q   <= wr_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign wr_count   = wr_count_q;
  assign drop_count = drop_count_q;
`else
  assign wr_count   = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_fb_writer.sv
// tb_fb_writer: directed and randomized checks of fb_writer against a
// transaction-level model (queue of expected writes, clear progress, counts).
// A reduced 40x30 framebuffer keeps clear sweeps short.
module tb_fb_writer;
  import fb_writer_pkg::*;

  localparam int W     = 40;
  localparam int H     = 30;
  localparam int AW    = 11;
  localparam int TOTAL = W * H;
  localparam logic [COLOR_BITS-1:0] CLR = 16'hA5C3;

  logic                  clk;
  logic                  rst_n;
  logic                  vld_in;
  logic                  rdy_in;
  logic [COLOR_BITS-1:0] color_in;
  coord_2d_t             pixel_in;
  logic                  clear_req;
  logic                  clear_busy;
  logic                  mem_req;
  logic                  mem_gnt;
  logic [AW-1:0]         mem_addr;
  logic [COLOR_BITS-1:0] mem_wdata;
  logic [31:0]           wr_count;
  logic [31:0]           drop_count;

  fb_writer #(
    .FB_WIDTH   (W),
    .FB_HEIGHT  (H),
    .ADDR_W     (AW),
    .CLEAR_COLOR(CLR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld_in    (vld_in),
    .rdy_in    (rdy_in),
    .color_in  (color_in),
    .pixel_in  (pixel_in),
    .clear_req (clear_req),
    .clear_busy(clear_busy),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .wr_count  (wr_count),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                    addr;
    logic [COLOR_BITS-1:0] color;
  } wr_t;

  wr_t q[$];
  int  n_cmp = 0;
  int  n_mis = 0;
  bit  busy = 0;
  bit  clearing = 0;
  int  clr_idx = 0;
  int  clr_writes = 0;
  int  wr_exp = 0;
  int  drop_exp = 0;

  function automatic int floor_fx(int v);
    int s;
    s = 1 << FX_FRAC_BITS;
    if (v >= 0) return v / s;
    return -((-v + s - 1) / s);
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(string tag);
`ifdef FB_STATS_EN
    check({tag, "_wr_count"}, wr_count, 64'(wr_exp));
    check({tag, "_drop_count"}, drop_count, 64'(drop_exp));
`else
    check({tag, "_wr_count"}, wr_count, 64'(0));
    check({tag, "_drop_count"}, drop_count, 64'(0));
`endif
  endtask

  task automatic set_px(int xi, int yi, logic [COLOR_BITS-1:0] c);
    vld_in     = 1'b1;
    pixel_in.x = 16'(xi * 16 + int'($urandom_range(0, 15)));
    pixel_in.y = 16'(yi * 16 + int'($urandom_range(0, 15)));
    color_in   = c;
  endtask

  // One clock: compare outputs against the model, then advance the model
  // with what the bench drove this cycle. Inputs are set at posedge+1.
  task automatic tick();
    bit  req_e, rdy_e, grant, start, b0;
    int  xi, yi;
    wr_t w;
    #1;
    b0    = busy;
    req_e = (q.size() != 0) || clearing;
    rdy_e = !busy && ((q.size() == 0) || mem_gnt);
    check("mem_req", mem_req, 64'(req_e));
    check("rdy_in", rdy_in, 64'(rdy_e));
    check("clear_busy", clear_busy, 64'(busy));
    if (q.size() != 0) begin
      check("px_addr", mem_addr, 64'(q[0].addr));
      check("px_wdata", mem_wdata, 64'(q[0].color));
    end else if (clearing) begin
      check("clr_addr", mem_addr, 64'(clr_idx));
      check("clr_wdata", mem_wdata, 64'(CLR));
    end
    start = busy && !clearing && (q.size() == 0);
    grant = req_e && mem_gnt;
    if (grant) begin
      if (q.size() != 0) begin
        void'(q.pop_front());
        wr_exp++;
      end else begin
        clr_idx++;
        clr_writes++;
        if (clr_idx == TOTAL) begin
          clearing = 0;
          busy     = 0;
          clr_idx  = 0;
        end
      end
    end
    if (start) clearing = 1;
    if (vld_in && rdy_e) begin
      xi = floor_fx(int'(pixel_in.x));
      yi = floor_fx(int'(pixel_in.y));
      if (xi >= 0 && xi < W && yi >= 0 && yi < H) begin
        w.addr  = yi * W + xi;
        w.color = color_in;
        q.push_back(w);
      end else begin
        drop_exp++;
      end
    end
    if (clear_req && !b0) busy = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    vld_in    = 1'b0;
    clear_req = 1'b0;
    mem_gnt   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    busy     = 0;
    clearing = 0;
    clr_idx  = 0;
    wr_exp   = 0;
    drop_exp = 0;
    #1;
    check("rst_rdy_in", rdy_in, 64'(1));
    check("rst_mem_req", mem_req, 64'(0));
    check("rst_mem_addr", mem_addr, 64'(0));
    check("rst_mem_wdata", mem_wdata, 64'(0));
    check("rst_clear_busy", clear_busy, 64'(0));
    check_counts("rst");
  endtask

  initial begin
    int cyc;
    bit timed_out;
    rst_n     = 1'b0;
    vld_in    = 1'b0;
    clear_req = 1'b0;
    mem_gnt   = 1'b0;
    color_in  = '0;
    pixel_in  = '0;

    do_reset();

    // consecutive in-bounds pixels with memory always granting
    mem_gnt = 1'b1;
    set_px(0, 0, 16'($urandom));
    tick();
    set_px(1, 0, 16'($urandom));
    tick();
    set_px(W - 1, H - 1, 16'($urandom));
    tick();
    vld_in = 1'b0;
    tick();
    tick();
    check_counts("stream");

    // off-screen fragments on each boundary are consumed and dropped
    set_px(-1, 5, 16'($urandom));
    tick();
    set_px(W, 0, 16'($urandom));
    tick();
    set_px(0, H, 16'($urandom));
    tick();
    vld_in = 1'b0;
    tick();
    tick();
    check_counts("oob");

    // memory stall holds the write; next pixel accepted in the grant cycle
    mem_gnt = 1'b0;
    set_px(10, 2, 16'($urandom));
    tick();
    vld_in = 1'b0;
    repeat (4) tick();
    mem_gnt = 1'b1;
    set_px(3, 4, 16'($urandom));
    tick();
    vld_in = 1'b0;
    tick();
    tick();
    check_counts("stall");

    // clear behind a held pixel, with a second request mid-sweep
    clr_writes = 0;
    mem_gnt = 1'b0;
    set_px(5, 5, 16'($urandom));
    tick();
    vld_in    = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (3) tick();
    cyc = 0;
    while (busy && cyc < TOTAL * 3) begin
      mem_gnt   = ($urandom % 4) != 0;
      clear_req = (cyc == 200);
      if ($urandom % 2 == 0) set_px(int'($urandom_range(0, W - 1)), 1, 16'($urandom));
      else vld_in = 1'b0;
      tick();
      cyc++;
    end
    clear_req = 1'b0;
    vld_in    = 1'b0;
    tick();
    check("clear_writes", clr_writes, 64'(TOTAL));
    check_counts("clear");

    // reset in the middle of a sweep, then a normal pixel write
    mem_gnt   = 1'b1;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    cyc = 0;
    while (clr_idx != 1000 && cyc < 1100) begin
      tick();
      cyc++;
    end
    check("reach_clr_1000", clr_idx, 64'(1000));
    do_reset();
    mem_gnt = 1'b1;
    set_px(7, 3, 16'($urandom));
    tick();
    vld_in = 1'b0;
    tick();
    tick();
    check_counts("post_rst");

    // randomized traffic with random stalls and occasional clears
    repeat (3000) begin
      if ($urandom % 3 != 0)
        set_px(int'($urandom_range(0, W + 5)) - 3, int'($urandom_range(0, H + 5)) - 3,
               16'($urandom));
      else vld_in = 1'b0;
      mem_gnt   = ($urandom % 3) != 0;
      clear_req = ($urandom % 1000) == 0;
      tick();
    end
    vld_in    = 1'b0;
    clear_req = 1'b0;
    mem_gnt   = 1'b1;
    cyc = 0;
    while ((busy || q.size() != 0) && cyc < TOTAL * 3) begin
      tick();
      cyc++;
    end
    timed_out = busy || (q.size() != 0);
    check("drain_timeout", 64'(timed_out), 64'(0));
    tick();
    check_counts("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
